// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between IF fetch and MEM load/store.
// One outstanding req/gnt/rvalid transaction; data-first with a fetch starvation bound.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  state_t      r_state, w_next;
  logic        r_owner;
  logic [3:0]  r_streak;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_addr, r_wdata;
  logic [31:0] r_if_rdata, r_d_rdata;
  logic        r_if_valid, r_d_valid;

  logic w_grant, w_pick_d, w_complete;

  assign w_grant    = (r_state == S_IDLE) && (if_req || d_req);
  // Data wins a collision unless fetch has already been passed over LIM times.
  assign w_pick_d   = d_req && (!if_req || (r_streak != LIM));
  assign w_complete = (r_state == S_WAIT) && mem_rvalid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (if_req || d_req) w_next = S_REQ;
      S_REQ:   if (mem_gnt)         w_next = S_WAIT;
      S_WAIT:  if (mem_rvalid)      w_next = S_DONE;
      S_DONE:                       w_next = S_IDLE;
      default:                      w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner    <= 1'b0;
      r_streak   <= 4'd0;
      r_we       <= 1'b0;
      r_be       <= 4'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_if_rdata <= 32'd0;
      r_d_rdata  <= 32'd0;
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
    end else begin
      if (w_grant) begin
        r_owner <= w_pick_d;
        if (w_pick_d) begin
          r_we    <= d_we;
          r_be    <= d_be;
          r_addr  <= d_addr;
          r_wdata <= d_wdata;
          if (!if_req)            r_streak <= 4'd0;
          else if (r_streak != LIM) r_streak <= r_streak + 4'd1;
        end else begin
          r_we     <= 1'b0;
          r_be     <= 4'hF;
          r_addr   <= if_addr;
          r_wdata  <= 32'd0;
          r_streak <= 4'd0;
        end
      end
      // Stores capture the ack data too; the requester ignores it.
      if (w_complete && !r_owner) r_if_rdata <= mem_rdata;
      if (w_complete &&  r_owner) r_d_rdata  <= mem_rdata;
      r_if_valid <= w_complete && !r_owner;
      r_d_valid  <= w_complete &&  r_owner;
    end
  end

  assign mem_req   = (r_state == S_REQ);
  assign mem_we    = r_we;
  assign mem_be    = r_be;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign if_valid  = r_if_valid;
  assign d_valid   = r_d_valid;
  assign stall_if  = if_req && !r_if_valid;
  assign stall_mem = d_req  && !r_d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, single fetch, collision,
// starvation bound, delayed grant and reset in the middle of a transaction.
module tb_mem_port_arbiter;

  logic        clk, rst;
  logic        if_req;
  logic [31:0] if_addr, if_rdata;
  logic        if_valid;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_valid;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall_if, stall_mem;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0;
    d_addr = 0; d_wdata = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (3) cyc();
    checks++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_valid, d_valid,
         if_rdata, d_rdata, stall_if, stall_mem} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got req=%b we=%b be=%h addr=%h wd=%h ifv=%b dv=%b ifr=%h dr=%h, want all 0",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_valid, d_valid, if_rdata, d_rdata);
    end
    rst = 1'b1;
    cyc(); cyc();
    checks++;
    if (mem_req !== 1'b0) begin
      failures++; $display("FAIL reset_idle_req: mem_req=%b want 0", mem_req);
    end
  endtask

  task automatic test_single_fetch();
    if_req = 1; if_addr = 32'h100;
    #1;
    checks++;
    if (stall_if !== 1'b1 || mem_req !== 1'b0) begin
      failures++; $display("FAIL fetch_c0: stall_if=%b mem_req=%b want 1 0", stall_if, mem_req);
    end
    cyc(); // cycle 1
    checks++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b0, 4'hF, 32'h100, 32'h0}) begin
      failures++;
      $display("FAIL fetch_c1_fields: req=%b we=%b be=%h addr=%h wd=%h want 1 0 f 00000100 0",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata);
    end
    mem_gnt = 1;
    cyc(); // cycle 2
    mem_gnt = 0;
    checks++;
    if (mem_req !== 1'b0 || if_valid !== 1'b0) begin
      failures++; $display("FAIL fetch_c2: mem_req=%b if_valid=%b want 0 0", mem_req, if_valid);
    end
    cyc(); // cycle 3
    checks++;
    if (if_valid !== 1'b0 || stall_if !== 1'b1) begin
      failures++; $display("FAIL fetch_c3: if_valid=%b stall_if=%b want 0 1", if_valid, stall_if);
    end
    mem_rvalid = 1; mem_rdata = 32'h00500093;
    cyc(); // cycle 4
    mem_rvalid = 0;
    checks++;
    if (if_valid !== 1'b1 || if_rdata !== 32'h00500093 || stall_if !== 1'b0) begin
      failures++;
      $display("FAIL fetch_c4: if_valid=%b if_rdata=%h stall_if=%b want 1 00500093 0",
               if_valid, if_rdata, stall_if);
    end
    if_req = 0;
    cyc(); // cycle 5
    checks++;
    if (if_valid !== 1'b0 || if_rdata !== 32'h00500093) begin
      failures++; $display("FAIL fetch_c5_hold: if_valid=%b if_rdata=%h want 0 00500093", if_valid, if_rdata);
    end
  endtask

  task automatic test_collision();
    if_req = 1; if_addr = 32'h104;
    d_req = 1; d_we = 1; d_addr = 32'h200; d_be = 4'b0011; d_wdata = 32'hAABBCCDD;
    #1;
    checks++;
    if (stall_if !== 1'b1 || stall_mem !== 1'b1) begin
      failures++; $display("FAIL coll_stall: stall_if=%b stall_mem=%b want 1 1", stall_if, stall_mem);
    end
    cyc(); // c1
    checks++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'h3, 32'h200, 32'hAABBCCDD}) begin
      failures++;
      $display("FAIL coll_data_fields: req=%b we=%b be=%h addr=%h wd=%h want 1 1 3 00000200 aabbccdd",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata);
    end
    mem_gnt = 1;
    cyc(); // c2
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h12345678;
    cyc(); // c3
    mem_rvalid = 0;
    checks++;
    if (d_valid !== 1'b1 || if_valid !== 1'b0 || stall_mem !== 1'b0 || stall_if !== 1'b1) begin
      failures++;
      $display("FAIL coll_d_done: d_valid=%b if_valid=%b stall_mem=%b stall_if=%b want 1 0 0 1",
               d_valid, if_valid, stall_mem, stall_if);
    end
    d_req = 0; d_we = 0;
    cyc(); // c4 idle
    checks++;
    if (mem_req !== 1'b0 || d_valid !== 1'b0) begin
      failures++; $display("FAIL coll_done_idle: mem_req=%b d_valid=%b want 0 0", mem_req, d_valid);
    end
    cyc(); // c5
    checks++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b0, 4'hF, 32'h104, 32'h0}) begin
      failures++;
      $display("FAIL coll_fetch_fields: req=%b we=%b be=%h addr=%h wd=%h want 1 0 f 00000104 0",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata);
    end
    mem_gnt = 1;
    cyc(); // c6
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h00000013;
    cyc(); // c7
    mem_rvalid = 0;
    checks++;
    if (if_valid !== 1'b1 || if_rdata !== 32'h13 || d_rdata !== 32'h12345678 || d_valid !== 1'b0) begin
      failures++;
      $display("FAIL coll_f_done: if_valid=%b if_rdata=%h d_rdata=%h d_valid=%b want 1 00000013 12345678 0",
               if_valid, if_rdata, d_rdata, d_valid);
    end
    if_req = 0;
    cyc();
  endtask

  task automatic test_starvation();
    logic [5:0] order;
    int n;
    logic prev_gnt;
    order = '0; n = 0; prev_gnt = 0;
    if_req = 1; if_addr = 32'h108;
    d_req = 1; d_we = 0; d_addr = 32'h20C; d_be = 4'hF; d_wdata = 0;
    for (int c = 0; c < 100 && n < 6; c++) begin
      cyc();
      if (d_valid) begin order[n] = 1'b1; n++; end
      else if (if_valid) begin order[n] = 1'b0; n++; end
      if (n < 6) begin
        mem_rvalid = prev_gnt;
        mem_rdata  = 32'h1000 + n;
        mem_gnt    = mem_req;
        prev_gnt   = mem_gnt;
      end
    end
    mem_gnt = 0; mem_rvalid = 0;
    if_req = 0; d_req = 0;
    checks++;
    if (n !== 6) begin
      failures++; $display("FAIL starve_budget: completions=%0d want 6", n);
    end
    // Completion order, index 0 first: D D D D F D
    checks++;
    if (order !== 6'b101111) begin
      failures++; $display("FAIL starve_order: order=%b want 101111 (bit0 first, 1=data)", order);
    end
    cyc(); cyc();
  endtask

  task automatic test_delayed_gnt();
    int cnt, vcyc;
    cnt = 0; vcyc = -1;
    d_req = 1; d_we = 0; d_addr = 32'h300; d_be = 4'hF;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      if (d_valid) begin cnt++; vcyc = c; end
      if (c <= 6) begin
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin
          failures++; $display("FAIL dly_req_stable c%0d: mem_req=%b mem_addr=%h want 1 00000300", c, mem_req, mem_addr);
        end
      end
      if (c == 3) begin mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; end
      if (c == 4) mem_rvalid = 0;
      if (c == 6) mem_gnt = 1;
      if (c == 7) mem_gnt = 0;
      if (c == 8) begin
        checks++;
        if (d_rdata === 32'hDEADBEEF) begin
          failures++; $display("FAIL dly_spurious: d_rdata=%h want not deadbeef", d_rdata);
        end
      end
      if (c == 9) begin mem_rvalid = 1; mem_rdata = 32'hCAFEF00D; end
      if (c == 10) begin
        mem_rvalid = 0;
        checks++;
        if (d_rdata !== 32'hCAFEF00D) begin
          failures++; $display("FAIL dly_rdata: d_rdata=%h want cafef00d", d_rdata);
        end
        d_req = 0;
      end
    end
    checks++;
    if (cnt !== 1 || vcyc !== 10) begin
      failures++; $display("FAIL dly_pulse: pulses=%0d at c%0d want 1 at c10", cnt, vcyc);
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    cnt = 0;
    if_req = 1; if_addr = 32'h400;
    cyc(); // c1
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h400) begin
      failures++; $display("FAIL rmid_req: mem_req=%b mem_addr=%h want 1 00000400", mem_req, mem_addr);
    end
    mem_gnt = 1;
    cyc(); // c2, WAIT
    mem_gnt = 0;
    rst = 0;
    #1;
    checks++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_valid, d_valid, if_rdata, d_rdata} !== '0) begin
      failures++;
      $display("FAIL rmid_async: req=%b be=%h addr=%h ifv=%b dv=%b ifr=%h dr=%h want all 0",
               mem_req, mem_be, mem_addr, if_valid, d_valid, if_rdata, d_rdata);
    end
    mem_rvalid = 1; mem_rdata = 32'hBADBAD00;
    cyc(); cyc();
    mem_rvalid = 0;
    rst = 1;
    cyc(); // restart: REQ
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h400 || if_valid !== 1'b0) begin
      failures++; $display("FAIL rmid_restart: mem_req=%b mem_addr=%h if_valid=%b want 1 00000400 0",
                           mem_req, mem_addr, if_valid);
    end
    mem_gnt = 1;
    cyc();
    mem_gnt = 0;
    if (if_valid) cnt++;
    mem_rvalid = 1; mem_rdata = 32'h00100073;
    cyc();
    mem_rvalid = 0;
    if (if_valid) cnt++;
    checks++;
    if (if_valid !== 1'b1 || if_rdata !== 32'h00100073) begin
      failures++; $display("FAIL rmid_done: if_valid=%b if_rdata=%h want 1 00100073", if_valid, if_rdata);
    end
    if_req = 0;
    cyc();
    if (if_valid) cnt++;
    checks++;
    if (cnt !== 1) begin
      failures++; $display("FAIL rmid_pulses: pulses=%0d want 1", cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_collision();
    test_starvation();
    test_delayed_gnt();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
